// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one pipelined arithmetic unit between N_REQ requesters.
// Define ALU_ARB_FIXED_PRIO_EN to switch arbitration to fixed priority (lowest index wins).
module alu_share_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DW      = 16,
    parameter int ALU_LAT = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [N_REQ*DW-1:0] req_a,
    input  logic [N_REQ*DW-1:0] req_b,
    input  logic [N_REQ*2-1:0]  req_op,
    output logic [DW-1:0]       alu_a,
    output logic [DW-1:0]       alu_b,
    output logic [1:0]          alu_op,
    input  logic [DW-1:0]       alu_result,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [2:0]          rsp_id,
    output logic [DW-1:0]       rsp_data,
    output logic                busy,
    output logic [31:0]         op_count
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          grant_any;
    logic [IW-1:0] grant_idx;
    logic [DW-1:0] sel_a;
    logic [DW-1:0] sel_b;
    logic [1:0]    sel_op;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic [IW-1:0] last_grant;
    logic [IW-1:0] rr_idx;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        req_ready = '0;
        grant_any = 1'b0;
        grant_idx = '0;
`ifdef ALU_ARB_FIXED_PRIO_EN
        // Descending scan: the last hit written is the lowest asserted index.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid[IW'(k)]) begin
                grant_any = 1'b1;
                grant_idx = IW'(k);
            end
        end
`else
        rr_idx = '0;
        // Descending distance from last_grant, so the nearest requester after it wins.
        for (int k = N_REQ; k >= 1; k--) begin
            rr_idx = IW'((int'(last_grant) + k >= N_REQ) ? (int'(last_grant) + k - N_REQ)
                                                          : (int'(last_grant) + k));
            if (req_valid[rr_idx]) begin
                grant_any = 1'b1;
                grant_idx = rr_idx;
            end
        end
`endif
        if (state != IDLE) begin
            grant_any = 1'b0;
        end
        if (grant_any) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (grant_idx == IW'(k)) begin
                sel_a  = req_a[k*DW +: DW];
                sel_b  = req_b[k*DW +: DW];
                sel_op = req_op[k*2 +: 2];
            end
        end
    end

    assign busy = (state != IDLE);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '0;
            op_count   <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant <= IW'(N_REQ - 1);
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        alu_a      <= sel_a;
                        alu_b      <= sel_b;
                        alu_op     <= sel_op;
                        rsp_id     <= 3'(grant_idx);
`ifndef ALU_ARB_FIXED_PRIO_EN
                        last_grant <= grant_idx;
`endif
                        op_count   <= op_count + 32'd1;
                        cnt        <= CW'(ALU_LAT - 1);
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    // Operands stay on alu_* so the unit sees a stable input for the whole latency.
                    if (cnt == '0) begin
                        rsp_data  <= alu_result;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: vector table, scoreboard on the response channel,
// and hand-written sequences for reset-in-flight, rotation, back-pressure and priority.
module tb_alu_share_arbiter;

    localparam int N_REQ   = 4;
    localparam int DW      = 16;
    localparam int ALU_LAT = 2;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic [N_REQ-1:0]    req_valid = '0;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ*DW-1:0] req_a = '0;
    logic [N_REQ*DW-1:0] req_b = '0;
    logic [N_REQ*2-1:0]  req_op = '0;
    logic [DW-1:0]       alu_a;
    logic [DW-1:0]       alu_b;
    logic [1:0]          alu_op;
    logic [DW-1:0]       alu_result = '0;
    logic                rsp_valid;
    logic                rsp_ready = 1'b1;
    logic [2:0]          rsp_id;
    logic [DW-1:0]       rsp_data;
    logic                busy;
    logic [31:0]         op_count;

    alu_share_arbiter #(.N_REQ(N_REQ), .DW(DW), .ALU_LAT(ALU_LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            id;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [1:0]    op;
        logic [DW-1:0] exp;
    } vec_t;

    typedef struct {
        logic [2:0]    id;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          sb_q[$];
    int            checks = 0;
    int            errors = 0;
    int            exp_count = 0;
    logic [DW-1:0] rq_exp [N_REQ];
    vec_t          vecs [6];

    // Unit model: one register stage; operands are held for the whole wait, so the
    // result is settled before the sampling edge ALU_LAT edges after accept.
    function automatic logic [DW-1:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [1:0] op);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    always @(posedge clk) alu_result <= alu_fn(alu_a, alu_b, alu_op);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_req(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic [1:0] op, input logic [DW-1:0] exp);
        req_a[id*DW +: DW] = a;
        req_b[id*DW +: DW] = b;
        req_op[id*2 +: 2]  = op;
        rq_exp[id]         = exp;
    endtask

    task automatic push_exp(input int g);
        rsp_t r;
        r.id   = 3'(g);
        r.data = rq_exp[g];
        sb_q.push_back(r);
        exp_count++;
    endtask

    // Response scoreboard: compare on every cycle a handshake is about to happen.
    always @(negedge clk) begin
        #1;
        if (!reset && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got id %0d data 0x%0h expected no response", rsp_id, rsp_data);
            end else begin
                rsp_t e;
                e = sb_q.pop_front();
                check("rsp_data", 32'(rsp_data), 32'(e.data));
                check("rsp_id", 32'(rsp_id), 32'(e.id));
            end
        end
    end

    task automatic wait_idle();
        int w = 0;
        while (busy && w < 50) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("idle_reached", 32'(busy), 32'd0);
    endtask

    // Issue one op from a lone requester; checks grant, hold, count and latency.
    task automatic run_vec(input vec_t v);
        int lat = 0;
        logic [N_REQ-1:0] exp_rdy;
        @(negedge clk);
        drive_req(v.id, v.a, v.b, v.op, v.exp);
        req_valid = '0;
        req_valid[v.id] = 1'b1;
        #1;
        exp_rdy = '0;
        exp_rdy[v.id] = 1'b1;
        check("req_ready_grant", 32'(req_ready), 32'(exp_rdy));
        push_exp(v.id);
        @(negedge clk);
        req_valid = '0;
        #1;
        check("busy_in_wait", 32'(busy), 32'd1);
        check("op_count", op_count, 32'(exp_count));
        check("alu_a_hold", 32'(alu_a), 32'(v.a));
        check("alu_op_hold", 32'(alu_op), 32'(v.op));
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            #1;
            lat++;
        end
        check("rsp_latency", 32'(lat), 32'(ALU_LAT));
        wait_idle();
    endtask

    // Caller is at a negedge with requests driven; records each accept and its cycle.
    task automatic collect(input int n, output int got[8], output int at[8], output int ng);
        ng = 0;
        for (int cyc = 0; cyc < 100 && ng < n; cyc++) begin
            #1;
            if (req_ready != '0) begin
                int g = -1;
                for (int k = 0; k < N_REQ; k++) if (req_ready[k]) g = k;
                check("grant_onehot", 32'($countones(req_ready)), 32'd1);
                got[ng] = g;
                at[ng]  = cyc;
                push_exp(g);
                ng++;
            end
            @(negedge clk);
        end
        check("grant_count", 32'(ng), 32'(n));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int got[8];
        int at[8];
        int ng;
        int exp_g;

        vecs[0] = '{0, 16'd100,   16'd23,    2'd0, 16'd123};
        vecs[1] = '{1, 16'h8000,  16'h0001,  2'd1, 16'h7FFF};
        vecs[2] = '{2, 16'h1234,  16'h00FF,  2'd2, 16'h0034};
        vecs[3] = '{3, 16'h0F0F,  16'hF000,  2'd3, 16'hFF0F};
        vecs[4] = '{0, 16'h7FFF,  16'h0001,  2'd0, 16'h8000};
        vecs[5] = '{3, 16'h0005,  16'h0009,  2'd1, 16'hFFFC};

        #2 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_op_count", op_count, 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Everyone requesting: rotation starting at 0 (last grant was 3), fixed ALU_LAT+2 spacing.
        @(negedge clk);
        for (int i = 0; i < N_REQ; i++)
            drive_req(i, DW'(10 * i + 5), DW'(i), 2'd0, DW'(11 * i + 5));
        req_valid = '1;
        collect(5, got, at, ng);
        req_valid = '0;
        for (int k = 0; k < ng; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_g = 0;
`else
            exp_g = k % N_REQ;
`endif
            check("rr_order", 32'(got[k]), 32'(exp_g));
            if (k > 0) check("rr_spacing", 32'(at[k] - at[k-1]), 32'(ALU_LAT + 2));
        end
        wait_idle();

        // Reset while the op is in flight: no response may ever appear for it.
        @(negedge clk);
        drive_req(0, 16'h0055, 16'h0011, 2'd0, 16'h0066);
        req_valid = 4'b0001;
        @(negedge clk);
        req_valid = '0;
        #1;
        check("inflight_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_op_count", op_count, 32'd0);
        check("mid_rst_alu_a", 32'(alu_a), 32'd0);
        check("mid_rst_alu_b", 32'(alu_b), 32'd0);
        check("mid_rst_alu_op", 32'(alu_op), 32'd0);
        check("mid_rst_rsp_id", 32'(rsp_id), 32'd0);
        check("mid_rst_rsp_data", 32'(rsp_data), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_count = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            check("post_rst_quiet", 32'(rsp_valid), 32'd0);
        end
        run_vec('{2, 16'h0003, 16'h0004, 2'd0, 16'h0007});

        // Back-pressure: response held 10 cycles while req1 waits ungranted.
        @(negedge clk);
        rsp_ready = 1'b0;
        drive_req(3, 16'h0100, 16'h0001, 2'd1, 16'h00FF);
        req_valid = 4'b1000;
        #1;
        check("bp_grant3", 32'(req_ready), 32'b1000);
        push_exp(3);
        @(negedge clk);
        drive_req(1, 16'h4000, 16'h4000, 2'd0, 16'h8000);
        req_valid = 4'b0010;
        #1;
        check("bp_no_grant_wait", 32'(req_ready), 32'd0);
        for (int w = 0; w < 20 && !rsp_valid; w++) begin
            @(negedge clk);
            #1;
        end
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            check("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold_data", 32'(rsp_data), 32'h00FF);
            check("bp_hold_id", 32'(rsp_id), 32'd3);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_busy", 32'(busy), 32'd1);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        check("bp_ready_in_resp", 32'(req_ready), 32'd0);
        @(negedge clk);
        #1;
        check("bp_next_grant", 32'(req_ready), 32'b0010);
        push_exp(1);
        @(negedge clk);
        req_valid = '0;
        #1;
        check("bp_op_count", op_count, 32'(exp_count));
        wait_idle();

        // Requesters 1 and 3 both valid, then 1 drops.
        @(negedge clk);
        drive_req(1, 16'h0007, 16'h0003, 2'd1, 16'h0004);
        drive_req(3, 16'h00F0, 16'h0F00, 2'd3, 16'h0FF0);
        req_valid = 4'b1010;
        collect(3, got, at, ng);
        for (int k = 0; k < ng; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp_g = 1;
`else
            exp_g = (k % 2 == 0) ? 3 : 1;
`endif
            check("prio_pair_grant", 32'(got[k]), 32'(exp_g));
        end
        req_valid = 4'b1000;
        collect(1, got, at, ng);
        if (ng > 0) check("prio_after_drop", 32'(got[0]), 32'd3);
        req_valid = '0;
        wait_idle();

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one arithmetic unit (operands A/B, 2-bit opcode, registered result, fixed pipeline latency) between N_REQ requesters inside the custom instrument.
- Arbitrates requests round-robin and registers the winner's operands onto the unit's inputs.
- Waits the unit's latency, captures the result, and returns it with the requester ID over a valid/ready response channel.
- Also exports a busy flag and an issued-operation counter for the status registers.

Parameters:
N_REQ, 4, number of requesters (2..8)
DW, 16, operand/result width (signed)
ALU_LAT, 2, clock edges from operand registers updating to result valid at alu_result (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  N_REQ  per-requester request valid
req_ready  out  N_REQ  per-requester accept, one-hot or zero
req_a  in  N_REQ*DW  operand A, requester i at [i*DW +: DW]
req_b  in  N_REQ*DW  operand B, same packing
req_op  in  N_REQ*2  opcode, requester i at [i*2 +: 2]
alu_a  out  DW  operand A to arithmetic unit (registered)
alu_b  out  DW  operand B to arithmetic unit (registered)
alu_op  out  2  opcode to arithmetic unit (registered)
alu_result  in  DW  arithmetic unit result
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  3  index of requester that owns rsp_data
rsp_data  out  DW  captured result
busy  out  1  high in any state except IDLE
op_count  out  32  accepted operations, wraps 2^32-1 -> 0

Behaviour:
- Reset (async assert, sync release) values:
  - state=IDLE; alu_a/alu_b/alu_op/rsp_data/rsp_id/op_count=0; rsp_valid=0; busy=0.
  - last_grant=N_REQ-1, so requester 0 has first priority.
  - Reset mid-operation discards the in-flight op and any pending response; no response is ever emitted for it.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready is combinational one-hot: the first asserted req_valid searching from last_grant+1 upward, modulo N_REQ. It is zero when no request is valid and always zero outside IDLE.
  - Transfer occurs at the edge where req_valid[i]&req_ready[i]. On that edge:
    - alu_a/alu_b/alu_op<=req_*[i]; rsp_id<=i; last_grant<=i.
    - op_count<=op_count+1; cnt<=ALU_LAT-1; state<=WAIT.
  - A requester may drop req_valid before being granted; arbitration re-evaluates every cycle.
- WAIT:
  - alu_* hold stable.
  - Each edge: if cnt==0, then rsp_data<=alu_result, rsp_valid<=1, state<=RESP; else cnt<=cnt-1.
  - Result is therefore sampled exactly ALU_LAT edges after the accept edge.
- RESP:
  - rsp_valid, rsp_id and rsp_data are held stable until the edge where rsp_ready=1.
  - On that edge: rsp_valid<=0, state<=IDLE.
  - rsp_ready while rsp_valid=0 is ignored.
- Throughput: with rsp_ready tied high, accept-to-accept spacing is ALU_LAT+2 cycles.
- Response latency: rsp_valid rises ALU_LAT cycles after the accept edge.
- alu_* retain the last issued operands in IDLE; they are not cleared.
- Simultaneous requests: only one grant per accept. Losers keep req_valid high and are served in rotation order. No requester waits more than N_REQ-1 other operations.
- Arithmetic: this block performs no arithmetic; data passes through bit-exact. op_count wraps silently.
- Indices >= N_REQ never appear on rsp_id; rsp_id upper bits are zero when N_REQ<8.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: round-robin is replaced by fixed priority. The lowest asserted req_valid index always wins; last_grant is unused and may be optimised away.
- Undefined: round-robin as specified above.
- All timing, FSM and response behaviour is identical in both builds.

Test Plan:
- Single op, ALU_LAT=2; bench ALU model (op 0=A+B, op 1=A-B, registered, 2-cycle latency). Req0 issues a=100, b=23, op=0 and is accepted at edge E.
  -> rsp_valid rises after E+2; rsp_data=123; rsp_id=0; op_count=1; busy high from E to the response handshake.
- Reset after accept, during WAIT -> rsp_valid stays 0; all outputs return to reset values; after release, req2 alone is granted and the response carries rsp_id=2.
- All four requesters hold valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; accept edges spaced exactly 4 cycles apart.
- Back-pressure: rsp_ready=0 for 10 cycles with a response pending -> rsp_valid, rsp_data and rsp_id are stable; req_ready=0 throughout; busy=1; next grant occurs the cycle after the rsp_ready handshake.
- Signed pass-through: req1 issues a=-32768, b=1, op=1 (A-B); the bench model returns 0x7FFF -> rsp_data=0x7FFF bit-exact; alu_a=0x8000 during WAIT.
- ALU_ARB_FIXED_PRIO_EN defined, requesters 1 and 3 continuously valid -> requester 1 is granted every operation; requester 3 is never granted until req_valid[1] drops.
